div32u16_seq: RTL and testbench

- Sequential unsigned divider, 32-bit dividend by 16-bit divisor, producing a 16-bit quotient and 16-bit remainder.
- Inverse companion of the 16x16 approximate multipliers: recovers an operand from a (possibly truncated) product.
- Optionally zeroes the dividend's low bits, matching the low-bit truncation of the approximate multipliers.
- Radix-2 restoring algorithm, one quotient bit per clock, valid/ready on both sides.

---
 rtl/div32u16_seq_if.sv | 62 ++++++
 rtl/div32u16_seq.sv | 182 ++++++++++++++++++
 tb/tb_div32u16_seq.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div32u16_seq_if.sv
// ---------------------------------------------------------------------------
// div32u16_seq_if
//
// Purpose:
//   Bundles the operand and result handshakes of the sequential 32/16
//   unsigned divider. The operand side (in_valid/in_ready/N/D) and the result
//   side (out_valid/out_ready/Q/R) are both valid/ready channels.
//
// Signals:
//   in_valid   producer -> divider  operands valid
//   in_ready   divider -> producer  divider can accept operands
//   N[31:0]    producer -> divider  dividend
//   D[15:0]    producer -> divider  divisor
//   out_valid  divider -> consumer  result valid
//   out_ready  consumer -> divider  consumer accepts result
//   Q[15:0]    divider -> consumer  quotient
//   R[15:0]    divider -> consumer  remainder
//   err        divider -> consumer  overflow flag (only with DIV_ERR_FLAG_EN)
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the divider itself
//
// Configuration macro: DIV_ERR_FLAG_EN adds the err signal.
// ---------------------------------------------------------------------------
interface div32u16_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] N;
  logic [15:0] D;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [15:0] R;
`ifdef DIV_ERR_FLAG_EN
  logic        err;
`endif

`ifdef DIV_ERR_FLAG_EN
  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R, err
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R, err
  );
`else
  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R
  );
`endif

endinterface

// File: rtl/div32u16_seq.sv
// ---------------------------------------------------------------------------
// div32u16_seq
//
// Purpose:
//   Sequential unsigned divider: 32-bit dividend by 16-bit divisor, giving a
//   16-bit quotient and 16-bit remainder. It is the inverse companion of the
//   16x16 approximate multipliers and recovers an operand from a (possibly
//   low-bit truncated) product. The TRUNC low bits of the dividend are forced
//   to zero before dividing so that the same truncation is applied on both
//   sides.
//
//   Radix-2 restoring division, one quotient bit per clock. Operands are
//   accepted only in IDLE. If the quotient cannot fit in 16 bits (upper half
//   of the effective dividend >= divisor, which includes D == 0) the result
//   saturates to Q = 16'hFFFF, R = 0 one cycle after accept. Otherwise the
//   result appears 17 cycles after the accept edge and is held until the
//   consumer takes it.
//
// Parameters:
//   TRUNC      number of dividend LSBs forced to zero (legal 0..16)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   bus        div32u16_seq_if.slave: in_valid/in_ready/N/D operand channel,
//              out_valid/out_ready/Q/R result channel (plus err, see below)
//
// Configuration macro:
//   DIV_ERR_FLAG_EN  when defined, bus.err is driven: 1 for saturated
//                    (overflow) results, 0 for normal results, reset 0.
//                    When undefined there is no err signal and a saturated
//                    result looks like a legitimate Q = FFFF, R = 0.
// ---------------------------------------------------------------------------
module div32u16_seq #(
  parameter int unsigned TRUNC = 8
) (
  input  logic           clk,
  input  logic           rst,
  div32u16_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mask that clears the TRUNC least significant dividend bits.
  localparam logic [31:0] TruncMask = ~((32'h1 << TRUNC) - 32'h1);

  state_t      state_q;

  // Partial remainder. It is always strictly smaller than the divisor, so
  // its 17th bit is implicitly zero between iterations and only exists in
  // the shifted trial value.
  logic [15:0] partRem_q;
  // Holds the not-yet-consumed dividend bits in its upper part and collects
  // quotient bits from the bottom; after 16 shifts it is the quotient.
  logic [15:0] quoShift_q;
  logic [15:0] divisor_q;
  logic [4:0]  count_q;

  logic        inReady_q;
  logic        outValid_q;
  logic [15:0] quo_q;
  logic [15:0] rem_q;
`ifdef DIV_ERR_FLAG_EN
  logic        err_q;
`endif

  logic [31:0] nEff_d;
  logic        ovf_d;
  logic [16:0] shifted_d;
  logic        fits_d;
  logic [15:0] nextRem_d;
  logic [15:0] nextQuo_d;

  // Operand-side decode: truncated dividend and the quotient-overflow test.
  // A 16-bit quotient is only possible when the upper dividend half is below
  // the divisor; D == 0 always fails this test and therefore saturates.
  always_comb begin
    nEff_d = bus.N & TruncMask;
    ovf_d  = (nEff_d[31:16] >= bus.D);
  end

  // One restoring-division step. The remainder is shifted left with the next
  // dividend bit (MSB first) and the divisor is trial-subtracted. When the
  // trial succeeds the difference is below the divisor and fits in 16 bits,
  // so the low 16 bits of the subtraction are the full new remainder.
  always_comb begin
    shifted_d = {partRem_q, quoShift_q[15]};
    fits_d    = (shifted_d >= {1'b0, divisor_q});
    nextRem_d = fits_d ? (shifted_d[15:0] - divisor_q) : shifted_d[15:0];
    nextQuo_d = {quoShift_q[14:0], fits_d};
  end

  // Control FSM and datapath registers. All handshake outputs are registered
  // here so in_ready/out_valid change only on clock edges. Reset aborts any
  // operation in flight and clears the datapath, so an aborted operation
  // never produces a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      partRem_q  <= '0;
      quoShift_q <= '0;
      divisor_q  <= '0;
      count_q    <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
`ifdef DIV_ERR_FLAG_EN
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady_q) begin
            inReady_q <= 1'b0;
            if (ovf_d) begin
              quo_q      <= 16'hFFFF;
              rem_q      <= 16'h0000;
              outValid_q <= 1'b1;
`ifdef DIV_ERR_FLAG_EN
              err_q      <= 1'b1;
`endif
              state_q    <= DONE;
            end else begin
              partRem_q  <= nEff_d[31:16];
              quoShift_q <= nEff_d[15:0];
              divisor_q  <= bus.D;
              count_q    <= 5'd16;
              state_q    <= BUSY;
            end
          end
        end

        BUSY: begin
          partRem_q  <= nextRem_d;
          quoShift_q <= nextQuo_d;
          count_q    <= count_q - 5'd1;
          // count_q == 1 means this edge performs the 16th iteration.
          if (count_q == 5'd1) begin
            quo_q      <= nextQuo_d;
            rem_q      <= nextRem_d;
            outValid_q <= 1'b1;
`ifdef DIV_ERR_FLAG_EN
            err_q      <= 1'b0;
`endif
            state_q    <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive the result channel straight from the registers.
  always_comb begin
    bus.in_ready  = inReady_q;
    bus.out_valid = outValid_q;
    bus.Q         = quo_q;
    bus.R         = rem_q;
`ifdef DIV_ERR_FLAG_EN
    bus.err       = err_q;
`endif
  end

endmodule

// File: tb/tb_div32u16_seq.sv
// ---------------------------------------------------------------------------
// tb_div32u16_seq
//
// Self-checking bench for div32u16_seq. Three instances with TRUNC = 0, 8
// and 16 share clock, reset and operand buses; only the selected instance
// sees in_valid, and its outputs are muxed onto the obs* signals. Expected
// results are pushed to a scoreboard queue when operands are driven and
// popped when the selected instance hands over a result.
// ---------------------------------------------------------------------------
module tb_div32u16_seq;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst;
  int          sel;
  logic        drvValid;
  logic [31:0] drvN;
  logic [15:0] drvD;
  logic        drvOutReady;

  logic        obsInReady;
  logic        obsOutValid;
  logic [15:0] obsQ;
  logic [15:0] obsR;
  logic        obsErr;

  int          errors = 0;
  int          checks = 0;
  exp_t        sbQueue[$];
  int          truncTab[3] = '{0, 8, 16};

  div32u16_seq_if bus0 ();
  div32u16_seq_if bus8 ();
  div32u16_seq_if bus16 ();

  div32u16_seq #(.TRUNC(0))  dut0  (.clk(clk), .rst(rst), .bus(bus0));
  div32u16_seq #(.TRUNC(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  div32u16_seq #(.TRUNC(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  assign bus0.in_valid   = drvValid && (sel == 0);
  assign bus8.in_valid   = drvValid && (sel == 1);
  assign bus16.in_valid  = drvValid && (sel == 2);
  assign bus0.N          = drvN;
  assign bus8.N          = drvN;
  assign bus16.N         = drvN;
  assign bus0.D          = drvD;
  assign bus8.D          = drvD;
  assign bus16.D         = drvD;
  assign bus0.out_ready  = drvOutReady;
  assign bus8.out_ready  = drvOutReady;
  assign bus16.out_ready = drvOutReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance onto the observation signals.
  always_comb begin
    obsInReady  = bus0.in_ready;
    obsOutValid = bus0.out_valid;
    obsQ        = bus0.Q;
    obsR        = bus0.R;
    obsErr      = 1'b0;
    case (sel)
      1: begin
        obsInReady  = bus8.in_ready;
        obsOutValid = bus8.out_valid;
        obsQ        = bus8.Q;
        obsR        = bus8.R;
      end
      2: begin
        obsInReady  = bus16.in_ready;
        obsOutValid = bus16.out_valid;
        obsQ        = bus16.Q;
        obsR        = bus16.R;
      end
      default: ;
    endcase
`ifdef DIV_ERR_FLAG_EN
    case (sel)
      1:       obsErr = bus8.err;
      2:       obsErr = bus16.err;
      default: obsErr = bus0.err;
    endcase
`endif
  end

  // Reference model: truncate, saturate on quotient overflow, else divide.
  function automatic exp_t refModel(input logic [31:0] n, input logic [15:0] d, input int trunc);
    logic [31:0] ne;
    exp_t        x;
    ne = n & (32'hFFFF_FFFF << trunc);
    if (ne[31:16] >= d) begin
      x.q = 16'hFFFF;
      x.r = 16'h0000;
      x.e = 1'b1;
    end else begin
      x.q = 16'(ne / {16'd0, d});
      x.r = 16'(ne % {16'd0, d});
      x.e = 1'b0;
    end
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one operation on the selected instance, wait (bounded) for its
  // result, take it and hand back what was observed and what was expected.
  task automatic applyStimulus(input logic [31:0] n, input logic [15:0] d, input exp_t expv,
                               output exp_t got, output exp_t want, output int lat);
    int w;
    drvN = n;
    drvD = d;
    drvValid = 1'b1;
    w = 0;
    while (!obsInReady && w < 50) begin
      tick;
      w++;
    end
    tick;
    drvValid = 1'b0;
    sbQueue.push_back(expv);
    lat = 1;
    while (!obsOutValid && lat < 60) begin
      tick;
      lat++;
    end
    got.q = obsQ;
    got.r = obsR;
    got.e = obsErr;
    want = sbQueue.pop_front();
    drvOutReady = 1'b1;
    tick;
    drvOutReady = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obsInReady !== 1'b1 || obsOutValid !== 1'b0 || obsQ !== 16'h0 || obsR !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_state sel=%0d got in_ready=%b out_valid=%b Q=%h R=%h want 1 0 0000 0000",
                 s, obsInReady, obsOutValid, obsQ, obsR);
      end
`ifdef DIV_ERR_FLAG_EN
      checks++;
      if (obsErr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_err sel=%0d got %b want 0", s, obsErr);
      end
`endif
    end
    sel = 0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_exact;
    exp_t got, want;
    int   lat;
    sel = 0;
    #1;
    applyStimulus(32'h0000_03E8, 16'd7, '{16'h008E, 16'h0006, 1'b0}, got, want, lat);
    checks++;
    if (got.q !== want.q || got.r !== want.r) begin
      errors++;
      $display("[TB] FAIL exact_1000_7 got Q=%h R=%h want Q=%h R=%h", got.q, got.r, want.q, want.r);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("[TB] FAIL exact_latency got %0d want 17", lat);
    end
`ifdef DIV_ERR_FLAG_EN
    checks++;
    if (got.e !== want.e) begin
      errors++;
      $display("[TB] FAIL exact_err got %b want %b", got.e, want.e);
    end
`endif
    checks++;
    if (obsInReady !== 1'b1 || obsOutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exact_release got in_ready=%b out_valid=%b want 1 0", obsInReady, obsOutValid);
    end
  endtask

  task automatic test_trunc;
    exp_t got, want;
    int   lat;
    sel = 1;
    #1;
    applyStimulus(32'h0001_2345, 16'h0010, '{16'h1230, 16'h0000, 1'b0}, got, want, lat);
    checks++;
    if (got.q !== want.q || got.r !== want.r || lat !== 17) begin
      errors++;
      $display("[TB] FAIL trunc8 got Q=%h R=%h lat=%0d want Q=%h R=%h lat=17",
               got.q, got.r, lat, want.q, want.r);
    end
    sel = 0;
    #1;
    applyStimulus(32'hFFFE_0001, 16'hFFFF, '{16'hFFFF, 16'h0000, 1'b0}, got, want, lat);
    checks++;
    if (got.q !== want.q || got.r !== want.r || lat !== 17) begin
      errors++;
      $display("[TB] FAIL max_nonovf got Q=%h R=%h lat=%0d want Q=%h R=%h lat=17",
               got.q, got.r, lat, want.q, want.r);
    end
`ifdef DIV_ERR_FLAG_EN
    checks++;
    if (got.e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_nonovf_err got %b want 0", got.e);
    end
`endif
  endtask

  task automatic test_overflow;
    exp_t got, want;
    int   lat;
    logic [31:0] nTab[2] = '{32'h0010_0000, 32'h0000_0005};
    logic [15:0] dTab[2] = '{16'h0010, 16'h0000};
    sel = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(nTab[i], dTab[i], '{16'hFFFF, 16'h0000, 1'b1}, got, want, lat);
      checks++;
      if (got.q !== want.q || got.r !== want.r) begin
        errors++;
        $display("[TB] FAIL overflow_%0d got Q=%h R=%h want Q=%h R=%h", i, got.q, got.r, want.q, want.r);
      end
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("[TB] FAIL overflow_latency_%0d got %0d want 1", i, lat);
      end
`ifdef DIV_ERR_FLAG_EN
      checks++;
      if (got.e !== 1'b1) begin
        errors++;
        $display("[TB] FAIL overflow_err_%0d got %b want 1", i, got.e);
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    exp_t        want;
    logic [15:0] q0, r0;
    int          w;
    sel = 0;
    #1;
    drvN = 32'd1000;
    drvD = 16'd7;
    drvValid = 1'b1;
    tick;
    sbQueue.push_back('{16'h008E, 16'h0006, 1'b0});
    drvValid = 1'b0;
    w = 0;
    while (!obsOutValid && w < 60) begin
      checks++;
      if (obsInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_busy_in_ready cycle=%0d got %b want 0", w, obsInReady);
      end
      drvN = 32'h0000_DEAD + w;
      drvD = 16'd3;
      drvValid = w[0];
      tick;
      w++;
    end
    want = sbQueue.pop_front();
    q0 = obsQ;
    r0 = obsR;
    checks++;
    if (obsOutValid !== 1'b1 || q0 !== want.q || r0 !== want.r) begin
      errors++;
      $display("[TB] FAIL bp_result got valid=%b Q=%h R=%h want 1 %h %h", obsOutValid, q0, r0, want.q, want.r);
    end
    for (int c = 0; c < 5; c++) begin
      drvValid = ~drvValid;
      drvN = 32'h0000_0011;
      tick;
      checks++;
      if (obsOutValid !== 1'b1 || obsQ !== want.q || obsR !== want.r || obsInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d got valid=%b Q=%h R=%h in_ready=%b want 1 %h %h 0",
                 c, obsOutValid, obsQ, obsR, obsInReady, want.q, want.r);
      end
    end
    drvValid = 1'b0;
    drvOutReady = 1'b1;
    tick;
    drvOutReady = 1'b0;
    checks++;
    if (obsInReady !== 1'b1 || obsOutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release got in_ready=%b out_valid=%b want 1 0", obsInReady, obsOutValid);
    end
  endtask

  task automatic test_reset_mid;
    exp_t got, want;
    int   lat;
    bit   sawValid;
    sel = 0;
    #1;
    drvN = 32'd1000;
    drvD = 16'd7;
    drvValid = 1'b1;
    tick;
    drvValid = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (obsInReady !== 1'b1 || obsOutValid !== 1'b0 || obsQ !== 16'h0 || obsR !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midreset_state got in_ready=%b out_valid=%b Q=%h R=%h want 1 0 0000 0000",
               obsInReady, obsOutValid, obsQ, obsR);
    end
    sawValid = 1'b0;
    repeat (25) begin
      tick;
      if (obsOutValid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_stale got out_valid=1 want 0");
    end
    applyStimulus(32'd100, 16'd9, '{16'd11, 16'd1, 1'b0}, got, want, lat);
    checks++;
    if (got.q !== want.q || got.r !== want.r || lat !== 17) begin
      errors++;
      $display("[TB] FAIL midreset_fresh got Q=%0d R=%0d lat=%0d want Q=%0d R=%0d lat=17",
               got.q, got.r, lat, want.q, want.r);
    end
  endtask

  task automatic checkOutput(input int s, input int numOps);
    int   recv;
    int   cyc;
    bit   hs;
    exp_t g, want;
    recv = 0;
    cyc = 0;
    while (recv < numOps && cyc < 3000) begin
      drvOutReady = ($urandom_range(0, 2) != 0);
      hs  = obsOutValid && drvOutReady;
      g.q = obsQ;
      g.r = obsR;
      g.e = obsErr;
      tick;
      cyc++;
      if (hs) begin
        recv++;
        checks++;
        if (sbQueue.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_spurious trunc=%0d got Q=%h R=%h want no output", truncTab[s], g.q, g.r);
        end else begin
          want = sbQueue.pop_front();
          if (g.q !== want.q || g.r !== want.r) begin
            errors++;
            $display("[TB] FAIL b2b_result trunc=%0d op=%0d got Q=%h R=%h want Q=%h R=%h",
                     truncTab[s], recv, g.q, g.r, want.q, want.r);
          end
`ifdef DIV_ERR_FLAG_EN
          checks++;
          if (g.e !== want.e) begin
            errors++;
            $display("[TB] FAIL b2b_err trunc=%0d op=%0d got %b want %b", truncTab[s], recv, g.e, want.e);
          end
`endif
        end
      end
    end
    drvOutReady = 1'b0;
    checks++;
    if (recv !== numOps) begin
      errors++;
      $display("[TB] FAIL b2b_count trunc=%0d got %0d want %0d", truncTab[s], recv, numOps);
    end
  endtask

  task automatic test_back_to_back;
    int numOps;
    numOps = 25;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      fork
        begin : driver
          for (int i = 0; i < numOps; i++) begin
            logic [31:0] n;
            logic [15:0] d;
            bit          accepted, wasReady;
            int          w;
            case ($urandom_range(0, 3))
              0: begin d = 16'h0; n = $urandom; end
              1: begin d = 16'($urandom) | 16'h1; n = $urandom; end
              default: begin
                d = 16'($urandom) | 16'h1;
                n = {16'($urandom_range(0, int'(d) - 1)), 16'($urandom)};
              end
            endcase
            repeat ($urandom_range(0, 2)) tick;
            drvN = n;
            drvD = d;
            drvValid = 1'b1;
            accepted = 1'b0;
            w = 0;
            while (!accepted && w < 200) begin
              wasReady = obsInReady;
              tick;
              w++;
              if (wasReady) accepted = 1'b1;
            end
            drvValid = 1'b0;
            if (accepted) sbQueue.push_back(refModel(n, d, truncTab[s]));
            else begin
              checks++;
              errors++;
              $display("[TB] FAIL b2b_accept trunc=%0d op=%0d got no accept want accept", truncTab[s], i);
            end
          end
        end
        checkOutput(s, numOps);
      join
      repeat (20) tick;
      checks++;
      if (obsOutValid !== 1'b0 || sbQueue.size() != 0) begin
        errors++;
        $display("[TB] FAIL b2b_drain trunc=%0d got out_valid=%b pending=%0d want 0 0",
                 truncTab[s], obsOutValid, sbQueue.size());
        sbQueue.delete();
      end
    end
    sel = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sel = 0;
    drvValid = 1'b0;
    drvN = '0;
    drvD = '0;
    drvOutReady = 1'b0;
    test_reset;
    test_exact;
    test_trunc;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
